// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// The result is computed in one shot when the operation is accepted and held
// in hi_tmp/lo_tmp. The counter only models the pipeline stall time, and the
// result is committed to hi/lo on the edge where busy falls.
// Handshake: an operation is accepted on any rising edge where start=1 and the
// unit is IDLE. While busy=1, start, hiwrite and lowrite are ignored.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hiwrite,
    input  logic        lowrite,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0]   hi_tmp, lo_tmp, hi_tmp_next, lo_tmp_next;
    logic [31:0]   hi_next, lo_next;
    logic          skip, skip_next;   // set for divide-by-zero: commit nothing

    // Datapath signals
    logic [63:0]   ext_a, ext_b, product;
    logic          neg_a, neg_b;
    logic [31:0]   mag_a, mag_b, divisor, uq, ur, quot, rem;
    logic          div_zero;

    assign busy = (state != IDLE);

    // Combinational multiply and sign-magnitude divide of the current operands.
    // Dividing magnitudes avoids the signed overflow case 0x80000000 / -1.
    always_comb begin
        ext_a    = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
        ext_b    = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
        product  = ext_a * ext_b;
        neg_a    = ~op[0] & a[31];
        neg_b    = ~op[0] & b[31];
        mag_a    = neg_a ? (~a + 32'd1) : a;
        mag_b    = neg_b ? (~b + 32'd1) : b;
        div_zero = (b == 32'd0);
        divisor  = div_zero ? 32'd1 : mag_b;
        uq       = mag_a / divisor;
        ur       = mag_a % divisor;
        quot     = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem      = neg_a ? (~ur + 32'd1) : ur;
    end

    // Next-state logic: accept ops and mt writes in IDLE, count down otherwise.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        hi_next     = hi;
        lo_next     = lo;
        hi_tmp_next = hi_tmp;
        lo_tmp_next = lo_tmp;
        skip_next   = skip;
        case (state)
            IDLE: begin
                if (hiwrite) hi_next = wdata;
                if (lowrite) lo_next = wdata;
                if (start) begin
                    if (op[1]) begin
                        state_next  = DIV;
                        cnt_next    = CW'(DIV_CYCLES);
                        hi_tmp_next = rem;
                        lo_tmp_next = quot;
                        skip_next   = div_zero;
                    end else begin
                        state_next  = MULT;
                        cnt_next    = CW'(MULT_CYCLES);
                        hi_tmp_next = product[63:32];
                        lo_tmp_next = product[31:0];
                        skip_next   = 1'b0;
                    end
                end
            end
            MULT, DIV: begin
                if (cnt <= CW'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (!skip) begin
                        hi_next = hi_tmp;
                        lo_next = lo_tmp;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and register update; reset clears everything and aborts any op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            skip   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            hi     <= hi_next;
            lo     <= lo_next;
            hi_tmp <= hi_tmp_next;
            lo_tmp <= lo_tmp_next;
            skip   <= skip_next;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: an arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_mult_div_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset, start, hiwrite, lowrite;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_wr = 1'b0;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hiwrite(hiwrite), .lowrite(lowrite), .wdata(wdata),
        .busy(busy), .hi(hi), .lo(lo)
    );

    // Clock
    always #5 clk = ~clk;

    // Model the operation result with plain 64-bit integer arithmetic
    task automatic model_start(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint sa, sb, ua, ub, r, q, rm;
        sa = longint'(signed'(ma));
        sb = longint'(signed'(mb));
        ua = longint'({32'b0, ma});
        ub = longint'({32'b0, mb});
        p_wr = 1'b1;
        if (!mop[1]) begin
            m_left = MULT_N;
            r = mop[0] ? ua * ub : sa * sb;
            p_hi = r[63:32];
            p_lo = r[31:0];
        end else begin
            m_left = DIV_N;
            if (mb == 32'd0) begin
                p_wr = 1'b0;
            end else begin
                q  = mop[0] ? ua / ub : sa / sb;
                rm = mop[0] ? ua % ub : sa % sb;
                p_lo = q[31:0];
                p_hi = rm[31:0];
            end
        end
    endtask

    // Cycle counter and model update on each rising edge
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            p_wr   = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else begin
            if (hiwrite) m_hi = wdata;
            if (lowrite) m_lo = wdata;
            if (start) model_start(op, a, b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
        end
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        cycle();
        start = 1'b0;
    endtask

    // Wait until busy drops, scrambling operands meanwhile; bounded
    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            a = $urandom;
            b = $urandom;
            cycle();
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, guard);
        end
    endtask

    // Run one op from IDLE and check duration and literal result
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int t0;
        do_start(o, x, y);
        t0 = cyc;
        wait_idle();
        check({name, "_dur"}, cyc - t0, n);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
    endtask

    initial begin
        int t0;
        reset = 1'b0; start = 1'b0; hiwrite = 1'b0; lowrite = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        cycle();
        chk_en = 1'b1;
        cycle();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;
        cycle();

        run_op("mult",   2'b00, 32'hFFFFFFFF, 32'h2, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu",  2'b01, 32'hFFFFFFFF, 32'h2, MULT_N, 32'h00000001, 32'hFFFFFFFE);
        run_op("multu2", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_N, 32'hFFFFFFFE, 32'h00000001);
        run_op("div",    2'b10, 32'hFFFFFFF9, 32'h2, DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div2",   2'b10, 32'h7, 32'hFFFFFFFE, DIV_N, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",   2'b11, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);

        // mthi / mtlo in IDLE, then divide by zero leaves them alone
        hiwrite = 1'b1; wdata = 32'h11;
        cycle();
        hiwrite = 1'b0; lowrite = 1'b1; wdata = 32'h22;
        cycle();
        lowrite = 1'b0;
        check("mt_hi", hi, 32'h11);
        check("mt_lo", lo, 32'h22);
        run_op("divzero", 2'b10, 32'd5, 32'd0, DIV_N, 32'h11, 32'h22);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h0, 32'h80000000);

        // start with mtlo, mthi while busy, second start while busy
        lowrite = 1'b1; wdata = 32'h5;
        do_start(2'b01, 32'd3, 32'd4);
        lowrite = 1'b0;
        t0 = cyc;
        check("mtlo_with_start", lo, 32'h5);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        hiwrite = 1'b1; wdata = 32'hABCD;
        cycle();
        hiwrite = 1'b0;
        check("mthi_ignored", hi, 32'h0);
        do_start(2'b11, 32'd100, 32'd7);
        wait_idle();
        check("restart_dur", cyc - t0, MULT_N);
        check("restart_hi", hi, 32'h0);
        check("restart_lo", lo, 32'hC);

        // reset on the 3rd busy cycle of divu aborts the op
        do_start(2'b11, 32'd1000, 32'd3);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (15) cycle();
        check("abort_late_busy", {31'b0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration for div/divu.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 The block SHALL expose these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low (0 = reset)
- start  input  1  E-stage mult/div instruction valid
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- a  input  32  rs operand (forwarded E value)
- b  input  32  rt operand (forwarded E value)
- hiwrite  input  1  mthi request
- lowrite  input  1  mtlo request
- wdata  input  32  mthi/mtlo data
- busy  output  1  operation in progress; hazard unit stalls D-stage mult/div/mfhi/mflo/mthi/mtlo while start|busy
- hi  output  32  HI register
- lo  output  32  LO register

Function
REQ-005 The block SHALL be an FSM with states IDLE, MULT and DIV, plus a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-006 In IDLE with start=1, it SHALL latch the full result into internal hi_tmp/lo_tmp and load cnt with MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1).
- Transition: MULT or DIV next edge.
REQ-007 busy SHALL equal (state != IDLE), registered, so it rises the cycle after the accepted start.
REQ-008 In MULT/DIV, cnt SHALL decrement each cycle.
- At cnt==1: state -> IDLE, hi<=hi_tmp, lo<=lo_tmp on the same edge busy falls.
- busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-009 mult SHALL produce the signed 64-bit product, multu the unsigned product; {hi,lo} = product.
REQ-010 div/divu SHALL give lo = quotient truncated toward zero and hi = remainder with the sign of the dividend (signed) or unsigned.
REQ-011 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000.
REQ-012 Division by zero SHALL still occupy DIV_CYCLES with busy high; hi/lo SHALL stay unchanged at completion.
REQ-013 start while busy SHALL be ignored: no relatch, no counter reload.
REQ-014 hiwrite/lowrite while busy SHALL be ignored.
REQ-015 hiwrite (lowrite) in IDLE SHALL write wdata to hi (lo) next edge; hiwrite and lowrite together SHALL write both.
REQ-016 start with hiwrite/lowrite in the same IDLE cycle SHALL accept both.
- The mt write lands next edge.
- Operation results overwrite it at completion.
REQ-017 Operands SHALL be sampled only on the accepted start cycle; a/b changes during busy SHALL have no effect.
REQ-018 hi/lo outputs SHALL be direct register outputs, with no combinational path from inputs.

Reset
REQ-019 reset=0 at a rising edge SHALL set state=IDLE, cnt=0, busy=0, hi=0, lo=0, hi_tmp=lo_tmp=0.
REQ-020 reset=0 mid-operation SHALL abort it: no result ever written, busy=0 the next cycle.
REQ-021 reset SHALL take priority over start, hiwrite and lowrite.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- mult: start, op=00, a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu, same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div by zero, prior hi=0x11, lo=0x22 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged; signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0xABCD during busy -> ignored; start with lowrite, wdata=0x5 -> lo=0x5 next cycle, then product at completion; second start mid-op -> no effect, busy still falls after the original 5.
- reset=0 on 3rd busy cycle of divu -> busy=0, hi=lo=0 next cycle, no later update.
